alu_serial: RTL and testbench
=============================

ALU_SERIAL -- requirements
Module: alu_serial

Interface
REQ-001 WIDTH, 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 op  input  3  0 XOR, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 NOR, 6 SHL, 7 SHR.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B; ignored for SHL/SHR.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 q  output  WIDTH  result word.
REQ-012 c  output  1  carry flag.
REQ-013 z  output  1  zero flag.

Function
REQ-014 The block SHALL be a bit-serial ALU driving one 1-bit slice LSB-first, one bit per clock.
REQ-015 FSM states SHALL be IDLE, RUN and DONE.
REQ-016 In IDLE, in_ready=1; in_valid=1 latches op, a, b, clears the bit counter, loads the carry flop with ci0 and moves to RUN.
REQ-017 ci0 SHALL be 1 for SUB and 0 for all other ops.
REQ-018 Slice ctrl SHALL be: XOR=B|XOR, ADD=B|SUM, SUB=B|NOTB|SUM, AND=B|AND, OR=B|OR, NOR=B|NOR, SHL=SHIFTL, SHR=SHIFTR.
REQ-019 Per RUN cycle: slice a=A[i], b=B[i], ci=carry flop, ri=A[i+1] (0 at MSB); q bit shifts into result register from MSB side; co loads carry flop.
REQ-020 RUN SHALL last exactly WIDTH cycles, then move to DONE.
REQ-021 Latency: request accepted at edge T gives out_valid=1 after edge T+WIDTH+1.
REQ-022 c SHALL equal the slice co of the MSB cycle: ADD carry-out, SUB no-borrow, SHL A[WIDTH-1], 0 for XOR/AND/OR/NOR/SHR.
REQ-023 In DONE, out_valid=1 and q, c, z SHALL be held stable until out_ready=1, then the FSM returns to IDLE.
REQ-024 in_ready SHALL be 0 in RUN and DONE; in_valid is ignored there.
REQ-025 out_ready asserted in the DONE-exit cycle SHALL NOT allow same-cycle acceptance; in_ready rises the cycle after.
REQ-026 out_valid SHALL be 0 outside DONE; q/c/z are don't-care then but SHALL NOT glitch X.

Reset
REQ-027 rst SHALL force IDLE, in_ready=1 on the following cycle, out_valid=0, q=0, c=0, z=0, counter=0, carry=0.
REQ-028 rst during RUN or DONE SHALL abort the operation and discard its result with no out_valid pulse.
REQ-029 rst SHALL take priority over in_valid and out_ready in the same cycle.

Configuration
REQ-030 Macro ALU_SERIAL_ZFLAG_EN defined: z=1 in DONE iff q==0, computed as a running OR of emitted bits.
REQ-031 ALU_SERIAL_ZFLAG_EN undefined: z port SHALL still exist and SHALL be tied to 0; no zero-detect logic.

Structure
REQ-032 Shared package alu_serial_pkg SHALL hold the op encoding, slice ctrl bit index constants (B=8, NOTB=7, SHIFTR=6, SHIFTL=5, NOR=4, OR=3, AND=2, SUM=1, XOR=0) and the FSM state type.
REQ-033 The op-to-ctrl/ci0 decode SHALL live in the package as a single pure mapping.
REQ-034 The design SHALL instantiate exactly one alu1b sub-module as the datapath slice; all other logic is local.

Verification
REQ-035 ADD a=8'h7F b=8'h01 -> q=8'h80, c=0, z=0, out_valid exactly 9 cycles after accept edge.
REQ-036 SUB a=8'h05 b=8'h05 -> q=8'h00, c=1, z=1 (z=0 without macro); SUB 8'h03-8'h05 -> q=8'hFE, c=0.
REQ-037 SHL a=8'h81 -> q=8'h02, c=1; SHR a=8'h81 -> q=8'h40, c=0.
REQ-038 NOR a=8'hF0 b=8'h0F -> q=8'h00; XOR 8'hAA,8'hFF -> 8'h55; AND 8'hCC,8'hAA -> 8'h88; OR -> 8'hEE.
REQ-039 out_ready held 0 for 5 cycles in DONE with in_valid=1 and changing a/b -> q/c stable, in_ready=0, no new accept.
REQ-040 rst pulsed on 4th RUN cycle -> no out_valid, in_ready=1 next cycle, following ADD 8'h01+8'h01 yields q=8'h02.

Source files
------------

// File: rtl/alu_serial_pkg.sv
// Shared definitions for the bit-serial ALU: op encoding, slice control bits, FSM states
// and the op-to-slice-control decode.
package alu_serial_pkg;

  localparam int CTRL_W      = 9;
  localparam int CTRL_B      = 8;
  localparam int CTRL_NOTB   = 7;
  localparam int CTRL_SHIFTR = 6;
  localparam int CTRL_SHIFTL = 5;
  localparam int CTRL_NOR    = 4;
  localparam int CTRL_OR     = 3;
  localparam int CTRL_AND    = 2;
  localparam int CTRL_SUM    = 1;
  localparam int CTRL_XOR    = 0;

  typedef enum logic [2:0] {
    OP_XOR = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_NOR = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic              ci0;
  } dec_t;

  // ci0=1 only for SUB: A + ~B + 1 gives two's-complement subtraction.
  function automatic dec_t op_decode(input logic [2:0] op);
    dec_t d;
    d.ctrl = '0;
    d.ci0  = 1'b0;
    case (op)
      OP_XOR: begin d.ctrl[CTRL_B] = 1'b1; d.ctrl[CTRL_XOR] = 1'b1; end
      OP_ADD: begin d.ctrl[CTRL_B] = 1'b1; d.ctrl[CTRL_SUM] = 1'b1; end
      OP_SUB: begin
        d.ctrl[CTRL_B]    = 1'b1;
        d.ctrl[CTRL_NOTB] = 1'b1;
        d.ctrl[CTRL_SUM]  = 1'b1;
        d.ci0             = 1'b1;
      end
      OP_AND: begin d.ctrl[CTRL_B] = 1'b1; d.ctrl[CTRL_AND] = 1'b1; end
      OP_OR:  begin d.ctrl[CTRL_B] = 1'b1; d.ctrl[CTRL_OR]  = 1'b1; end
      OP_NOR: begin d.ctrl[CTRL_B] = 1'b1; d.ctrl[CTRL_NOR] = 1'b1; end
      OP_SHL: d.ctrl[CTRL_SHIFTL] = 1'b1;
      OP_SHR: d.ctrl[CTRL_SHIFTR] = 1'b1;
      default: d.ctrl = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_serial_alu1b.sv
// One-bit ALU slice, purely combinational; the serial top drives it once per bit.
module alu1b
  import alu_serial_pkg::*;
(
  input  logic              a,
  input  logic              b,
  input  logic              ci,
  input  logic              ri,
  input  logic [CTRL_W-1:0] ctrl,
  output logic              q,
  output logic              co
);

  logic bb;

  always_comb begin
    bb = ctrl[CTRL_B] & (b ^ ctrl[CTRL_NOTB]);
    q  = 1'b0;
    co = 1'b0;
    if (ctrl[CTRL_SUM]) begin
      q  = a ^ bb ^ ci;
      co = (a & bb) | (a & ci) | (bb & ci);
    end else if (ctrl[CTRL_XOR]) begin
      q = a ^ bb;
    end else if (ctrl[CTRL_AND]) begin
      q = a & bb;
    end else if (ctrl[CTRL_OR]) begin
      q = a | bb;
    end else if (ctrl[CTRL_NOR]) begin
      q = ~(a | bb);
    end else if (ctrl[CTRL_SHIFTL]) begin
      // carry flop carries the previous (lower) A bit up one position
      q  = ci;
      co = a;
    end else if (ctrl[CTRL_SHIFTR]) begin
      q = ri;
    end
  end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial ALU, LSB first, one bit per clock; result published one cycle after the last bit.
// Optional zero flag enabled by defining ALU_SERIAL_ZFLAG_EN; otherwise z is tied low.
module alu_serial
  import alu_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             c,
  output logic             z
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e            state;
  state_e            state_nxt;
  logic              accept;
  logic              running;
  logic              publish;
  logic              last_bit;

  dec_t              dec_in;
  logic [CTRL_W-1:0] ctrl_r;
  logic [WIDTH-1:0]  a_sh;
  logic [WIDTH-1:0]  b_sh;
  logic [WIDTH-1:0]  res;
  logic              carry;
  logic [CW-1:0]     cnt;
  logic              slice_q;
  logic              slice_co;

  assign dec_in   = op_decode(op);
  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)               state_nxt = ST_RUN;
      ST_RUN:  if (last_bit)               state_nxt = ST_DONE;
      ST_DONE: if (out_valid && out_ready) state_nxt = ST_IDLE;
      default:                             state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == ST_IDLE);
    accept   = in_ready && in_valid;
    running  = (state == ST_RUN);
    publish  = (state == ST_DONE) && !out_valid;
  end

  // A and B shift right so the slice always sees bit i at [0] and A[i+1] at [1];
  // the zero shifted in at the top supplies ri=0 on the MSB cycle.
  alu1b u_slice (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .ci   (carry),
    .ri   (a_sh[1]),
    .ctrl (ctrl_r),
    .q    (slice_q),
    .co   (slice_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_r    <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      res       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      q         <= '0;
      c         <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        ctrl_r <= dec_in.ctrl;
        a_sh   <= a;
        b_sh   <= b;
        carry  <= dec_in.ci0;
        cnt    <= '0;
      end else if (running) begin
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        res   <= {slice_q, res[WIDTH-1:1]};
        carry <= slice_co;
        cnt   <= cnt + 1'b1;
      end
      if (publish) begin
        q         <= res;
        c         <= carry;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_SERIAL_ZFLAG_EN
  logic nz;

  always_ff @(posedge clk) begin
    if (rst) begin
      nz <= 1'b0;
      z  <= 1'b0;
    end else begin
      if (accept)       nz <= 1'b0;
      else if (running) nz <= nz | slice_q;
      if (publish)      z  <= ~nz;
    end
  end
`else
  assign z = 1'b0;
`endif

endmodule

// File: tb/tb_alu_serial.sv
// Self-checking bench for alu_serial: vector table through a scoreboard queue, plus stall and reset-abort sequences.
module tb_alu_serial;

  localparam int W = 8;
`ifdef ALU_SERIAL_ZFLAG_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] q;
  logic         c;
  logic         z;

  alu_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .c         (c),
    .z         (z)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eq;
    logic         ec;
  } vec_t;

  typedef struct {
    logic [W-1:0] q;
    logic         c;
    logic         z;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [W-1:0] eq, input logic ec);
    exp_t e;
    int   n;
    @(negedge clk);
    for (n = 0; n < 50 && !in_ready; n++) @(negedge clk);
    if (n == 50) check("in_ready_wait", 32'd0, 32'd1);
    in_valid = 1'b1;
    op = o; a = av; b = bv;
    @(posedge clk);
    e.q = eq; e.c = ec; e.z = ZF ? (eq == '0) : 1'b0;
    sb.push_back(e);
    #1 in_valid = 1'b0;
    check("in_ready_low_in_run", {31'd0, in_ready}, 32'd0);
  endtask

  // Counts edges after the accept edge until out_valid; expected WIDTH+1.
  task automatic wait_out(input string name);
    int n;
    for (n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) break;
    end
    check({name, "_latency"}, n, W + 1);
  endtask

  task automatic take(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({name, "_q"}, {24'd0, q}, {24'd0, e.q});
    check({name, "_c"}, {31'd0, c}, {31'd0, e.c});
    check({name, "_z"}, {31'd0, z}, {31'd0, e.z});
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({name, "_drop_valid"}, {31'd0, out_valid}, 32'd0);
    check({name, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{3'd1, 8'h7F, 8'h01, 8'h80, 1'b0};
    vecs[1]  = '{3'd2, 8'h05, 8'h05, 8'h00, 1'b1};
    vecs[2]  = '{3'd2, 8'h03, 8'h05, 8'hFE, 1'b0};
    vecs[3]  = '{3'd6, 8'h81, 8'h5A, 8'h02, 1'b1};
    vecs[4]  = '{3'd7, 8'h81, 8'hA5, 8'h40, 1'b0};
    vecs[5]  = '{3'd5, 8'hF0, 8'h0F, 8'h00, 1'b0};
    vecs[6]  = '{3'd0, 8'hAA, 8'hFF, 8'h55, 1'b0};
    vecs[7]  = '{3'd3, 8'hCC, 8'hAA, 8'h88, 1'b0};
    vecs[8]  = '{3'd4, 8'hCC, 8'hAA, 8'hEE, 1'b0};
    vecs[9]  = '{3'd1, 8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[10] = '{3'd2, 8'h00, 8'h01, 8'hFF, 1'b0};
    vecs[11] = '{3'd6, 8'h40, 8'h00, 8'h80, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_q",         {24'd0, q},         32'd0);
    check("rst_c",         {31'd0, c},         32'd0);
    check("rst_z",         {31'd0, z},         32'd0);

    for (int i = 0; i < 12; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eq, vecs[i].ec);
      wait_out($sformatf("vec%0d", i));
      take($sformatf("vec%0d", i));
    end

    // Stall in DONE with a competing request on the input.
    send(3'd1, 8'h7F, 8'h01, 8'h80, 1'b0);
    wait_out("stall");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      op = 3'($urandom_range(0, 7));
      a = W'($urandom); b = W'($urandom);
      @(posedge clk);
      #1;
      check("stall_q",         {24'd0, q},         32'h80);
      check("stall_c",         {31'd0, c},         32'd0);
      check("stall_in_ready",  {31'd0, in_ready},  32'd0);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    take("stall");

    // Reset during the 4th RUN cycle drops the operation.
    send(3'd2, 8'h03, 8'h05, 8'hFE, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    void'(sb.pop_back());
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_in_ready",  {31'd0, in_ready},  32'd1);
    begin
      logic seen;
      seen = 1'b0;
      repeat (12) begin
        @(posedge clk);
        #1 seen = seen | out_valid;
      end
      check("abort_no_valid", {31'd0, seen}, 32'd0);
    end
    send(3'd1, 8'h01, 8'h01, 8'h02, 1'b0);
    wait_out("post_abort");
    take("post_abort");

    check("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
